// File: rtl/bat_control_sequencer_pkg.sv
// Shared types and constants for the Bat Amateur CPU control sequencer:
// opcodes, control-word bit indices, FSM states and bus transfer endpoints.
package bat_control_sequencer_pkg;

    localparam int OPC_W  = 4;
    localparam int CTRL_W = 16;

    // Opcodes (INSTRUCTION[15:12]); A..E are undefined and behave as NOP.
    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_STA = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 4'h9;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    // Control word bit indices; bits 14 and 15 are spare and always 0.
    localparam int PC_EN    = 0;
    localparam int PC_LOAD  = 1;
    localparam int PC_COUNT = 2;
    localparam int MAR_LOAD = 3;
    localparam int RAM_EN   = 4;
    localparam int RAM_LOAD = 5;
    localparam int IR_EN    = 6;
    localparam int IR_LOAD  = 7;
    localparam int A_EN     = 8;
    localparam int A_LOAD   = 9;
    localparam int B_LOAD   = 10;
    localparam int ALU_EN   = 11;
    localparam int ALU_SUB  = 12;
    localparam int OUT_LOAD = 13;

    typedef enum logic [3:0] {
        ST_IDLE, ST_F0_DRV, ST_F0_LAT, ST_F1_DRV, ST_F1_LAT, ST_DECODE,
        ST_E0_DRV, ST_E0_LAT, ST_E1_DRV, ST_E1_LAT, ST_E2_DRV, ST_E2_LAT, ST_HALT
    } state_t;

    // Bus source (drives via *_EN) and destination (captures via *_LOAD).
    typedef enum logic [2:0] {SRC_NONE, SRC_PC, SRC_RAM, SRC_IR, SRC_A, SRC_ALU} src_t;
    typedef enum logic [2:0] {DST_NONE, DST_PC, DST_MAR, DST_RAM, DST_IR, DST_A, DST_B, DST_OUT} dst_t;

    // Number of execute transfers an instruction needs; conditional jumps
    // that are not taken, NOP, HLT and undefined opcodes need none.
    function automatic logic [1:0] op_steps(input logic [OPC_W-1:0] op,
                                            input logic z, input logic c);
        case (op)
            OP_LDA, OP_STA:         op_steps = 2'd2;
            OP_ADD, OP_SUB:         op_steps = 2'd3;
            OP_LDI, OP_JMP, OP_OUT: op_steps = 2'd1;
            OP_JZ:                  op_steps = z ? 2'd1 : 2'd0;
            OP_JC:                  op_steps = c ? 2'd1 : 2'd0;
            default:                op_steps = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/bat_control_sequencer_decode.sv
// Combinational instruction decoder: maps the held opcode/flags and the
// execute step index to the bus source and destination of that step.
module bat_control_sequencer_decode
    import bat_control_sequencer_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic [1:0]       step,
    output src_t             src,
    output dst_t             dst,
    output logic             alu_sub,
    output logic [1:0]       n_steps
);

    // Per-opcode transfer table, indexed by execute step.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        src     = SRC_NONE;
        dst     = DST_NONE;
        alu_sub = (opcode == OP_SUB);
        n_steps = op_steps(opcode, flag_z, flag_c);
        case (opcode)
            OP_LDA, OP_STA: begin
                if (step == 2'd0) begin
                    src = SRC_IR;
                    dst = DST_MAR;
                end else if (step == 2'd1) begin
                    src = (opcode == OP_LDA) ? SRC_RAM : SRC_A;
                    dst = (opcode == OP_LDA) ? DST_A   : DST_RAM;
                end
            end
            OP_ADD, OP_SUB: begin
                case (step)
                    2'd0:    begin src = SRC_IR;  dst = DST_MAR; end
                    2'd1:    begin src = SRC_RAM; dst = DST_B;   end
                    2'd2:    begin src = SRC_ALU; dst = DST_A;   end
                    default: begin src = SRC_NONE; dst = DST_NONE; end
                endcase
            end
            OP_LDI: begin src = SRC_IR; dst = DST_A; end
            OP_JMP: begin src = SRC_IR; dst = DST_PC; end
            OP_JZ:  if (flag_z) begin src = SRC_IR; dst = DST_PC; end
            OP_JC:  if (flag_c) begin src = SRC_IR; dst = DST_PC; end
            OP_OUT: begin src = SRC_A; dst = DST_OUT; end
            default: begin src = SRC_NONE; dst = DST_NONE; end
        endcase
    end

endmodule

// File: rtl/bat_control_sequencer.sv
// Fetch/decode/execute sequencer for the Bat Amateur CPU. Every bus transfer
// is a DRV cycle (source enabled) followed by a LAT cycle (source still
// enabled, destination loading), so only one source ever drives the bus.
module bat_control_sequencer
    import bat_control_sequencer_pkg::*;
#(
    parameter int BUS_WIDTH = 16,
    parameter int OP_W      = OPC_W
) (
    input  logic                 CLOCK,
    input  logic                 RESET_N,
    input  logic [BUS_WIDTH-1:0] INSTRUCTION,
    input  logic                 FLAG_Z,
    input  logic                 FLAG_C,
    input  logic                 RUN,
    input  logic                 STEP_MODE,
    input  logic                 STEP,
    output logic [CTRL_W-1:0]    CTRL,
    output logic                 HALTED,
    output logic                 BUSY
);

    state_t            state_q, state_d;
    logic              step_q;
    logic [OP_W-1:0]   op_q;
    logic              z_q, c_q;
    logic [OP_W-1:0]   op_in;
    logic              step_edge;
    logic [1:0]        exec_step;
    src_t              dec_src, xfer_src;
    dst_t              dec_dst, xfer_dst;
    logic              dec_alu_sub, latch, pc_count, in_exec;
    logic [1:0]        dec_n_steps;
    state_t            end_state;

    assign op_in     = INSTRUCTION[BUS_WIDTH-1 -: OP_W];
    assign step_edge = STEP & ~step_q;

    // The operand field goes to the bus through the IR itself; it is not consumed here.
    logic unused_operand;
    assign unused_operand = ^INSTRUCTION[BUS_WIDTH-OP_W-1:0];

    bat_control_sequencer_decode u_decode (
        .opcode  (op_q),
        .flag_z  (z_q),
        .flag_c  (c_q),
        .step    (exec_step),
        .src     (dec_src),
        .dst     (dec_dst),
        .alu_sub (dec_alu_sub),
        .n_steps (dec_n_steps)
    );

    // State, step-edge history and the opcode/flags captured in DECODE.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            step_q  <= 1'b0;
            op_q    <= OP_NOP;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            step_q  <= STEP;
            if (state_q == ST_DECODE) begin
                op_q <= op_in;
                z_q  <= FLAG_Z;
                c_q  <= FLAG_C;
            end
        end
    end

    // Next-state: fetch, decode, up to three execute transfers, then refetch or idle.
    always_comb begin
        end_state = (RUN && !STEP_MODE) ? ST_F0_DRV : ST_IDLE;
        state_d   = state_q;
        case (state_q)
            ST_IDLE:   if (RUN && (!STEP_MODE || step_edge)) state_d = ST_F0_DRV;
            ST_F0_DRV: state_d = ST_F0_LAT;
            ST_F0_LAT: state_d = ST_F1_DRV;
            ST_F1_DRV: state_d = ST_F1_LAT;
            ST_F1_LAT: state_d = ST_DECODE;
            ST_DECODE: begin
                if (op_in == OP_HLT)                              state_d = ST_HALT;
                else if (op_steps(op_in, FLAG_Z, FLAG_C) == 2'd0) state_d = end_state;
                else                                              state_d = ST_E0_DRV;
            end
            ST_E0_DRV: state_d = ST_E0_LAT;
            ST_E0_LAT: state_d = (dec_n_steps == 2'd1) ? end_state : ST_E1_DRV;
            ST_E1_DRV: state_d = ST_E1_LAT;
            ST_E1_LAT: state_d = (dec_n_steps == 2'd2) ? end_state : ST_E2_DRV;
            ST_E2_DRV: state_d = ST_E2_LAT;
            ST_E2_LAT: state_d = end_state;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore outputs: transfer selection from the registered state, then strobe encoding.
    always_comb begin
        xfer_src  = SRC_NONE;
        xfer_dst  = DST_NONE;
        latch     = 1'b0;
        pc_count  = 1'b0;
        in_exec   = 1'b0;
        exec_step = 2'd0;
        case (state_q)
            ST_F0_DRV: xfer_src = SRC_PC;
            ST_F0_LAT: begin xfer_src = SRC_PC;  xfer_dst = DST_MAR; latch = 1'b1; end
            ST_F1_DRV: xfer_src = SRC_RAM;
            ST_F1_LAT: begin xfer_src = SRC_RAM; xfer_dst = DST_IR;  latch = 1'b1; pc_count = 1'b1; end
            ST_E0_DRV, ST_E1_DRV, ST_E2_DRV,
            ST_E0_LAT, ST_E1_LAT, ST_E2_LAT: begin
                in_exec   = 1'b1;
                exec_step = (state_q == ST_E0_DRV || state_q == ST_E0_LAT) ? 2'd0 :
                            (state_q == ST_E1_DRV || state_q == ST_E1_LAT) ? 2'd1 : 2'd2;
                latch     = (state_q == ST_E0_LAT || state_q == ST_E1_LAT || state_q == ST_E2_LAT);
                xfer_src  = dec_src;
                xfer_dst  = dec_dst;
            end
            default: ;
        endcase

        CTRL = '0;
        case (xfer_src)
            SRC_PC:  CTRL[PC_EN]  = 1'b1;
            SRC_RAM: CTRL[RAM_EN] = 1'b1;
            SRC_IR:  CTRL[IR_EN]  = 1'b1;
            SRC_A:   CTRL[A_EN]   = 1'b1;
            SRC_ALU: CTRL[ALU_EN] = 1'b1;
            default: ;
        endcase
        if (latch) begin
            case (xfer_dst)
                DST_PC:  CTRL[PC_LOAD]  = 1'b1;
                DST_MAR: CTRL[MAR_LOAD] = 1'b1;
                DST_RAM: CTRL[RAM_LOAD] = 1'b1;
                DST_IR:  CTRL[IR_LOAD]  = 1'b1;
                DST_A:   CTRL[A_LOAD]   = 1'b1;
                DST_B:   CTRL[B_LOAD]   = 1'b1;
                DST_OUT: CTRL[OUT_LOAD] = 1'b1;
                default: ;
            endcase
        end
        CTRL[PC_COUNT] = pc_count;
        CTRL[ALU_SUB]  = in_exec & dec_alu_sub;
    end

    assign HALTED = (state_q == ST_HALT);
    assign BUSY   = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_bat_control_sequencer.sv
// Directed testbench for bat_control_sequencer: exact per-cycle control words
// for fetch and each instruction class, reset, single-step and halt behaviour.
module tb_bat_control_sequencer;

    localparam logic [15:0] C_PC_EN    = 16'h0001;
    localparam logic [15:0] C_PC_LOAD  = 16'h0002;
    localparam logic [15:0] C_PC_COUNT = 16'h0004;
    localparam logic [15:0] C_MAR_LOAD = 16'h0008;
    localparam logic [15:0] C_RAM_EN   = 16'h0010;
    localparam logic [15:0] C_RAM_LOAD = 16'h0020;
    localparam logic [15:0] C_IR_EN    = 16'h0040;
    localparam logic [15:0] C_IR_LOAD  = 16'h0080;
    localparam logic [15:0] C_A_EN     = 16'h0100;
    localparam logic [15:0] C_A_LOAD   = 16'h0200;
    localparam logic [15:0] C_B_LOAD   = 16'h0400;
    localparam logic [15:0] C_ALU_EN   = 16'h0800;
    localparam logic [15:0] C_ALU_SUB  = 16'h1000;
    localparam logic [15:0] C_OUT_LOAD = 16'h2000;
    localparam logic [15:0] EN_MASK    = C_PC_EN | C_RAM_EN | C_IR_EN | C_A_EN | C_ALU_EN;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic [15:0] INSTRUCTION;
    logic        FLAG_Z, FLAG_C, RUN, STEP_MODE, STEP;
    logic [15:0] CTRL;
    logic        HALTED, BUSY;

    int n_checks = 0;
    int n_bad    = 0;
    logic [15:0] exp_tab [0:11];

    bat_control_sequencer dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .INSTRUCTION (INSTRUCTION),
        .FLAG_Z      (FLAG_Z),
        .FLAG_C      (FLAG_C),
        .RUN         (RUN),
        .STEP_MODE   (STEP_MODE),
        .STEP        (STEP),
        .CTRL        (CTRL),
        .HALTED      (HALTED),
        .BUSY        (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fetch is identical for every instruction: PC->MAR, RAM->IR (+count), DECODE.
    task automatic set_fetch();
        exp_tab[0] = C_PC_EN;
        exp_tab[1] = C_PC_EN | C_MAR_LOAD;
        exp_tab[2] = C_RAM_EN;
        exp_tab[3] = C_RAM_EN | C_IR_LOAD | C_PC_COUNT;
        exp_tab[4] = 16'h0000;
    endtask

    // Start one instruction from IDLE and compare CTRL cycle by cycle against exp_tab.
    // Without keep_run, RUN drops in cycle 1 and the instruction must still finish.
    task automatic run_seq(input string tag, input logic [15:0] instr, input logic z,
                           input logic c, input int n, input bit keep_run);
        INSTRUCTION = instr;
        FLAG_Z = z;
        FLAG_C = c;
        RUN = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK);
            chk({tag, "_ctrl"}, CTRL, exp_tab[i]);
            chk({tag, "_busy"}, BUSY, 1'b1);
            chk({tag, "_one_en"}, ($countones(CTRL & EN_MASK) <= 1), 1'b1);
            if (i == 0 && !keep_run) RUN = 1'b0;
            if (i == 5) begin
                FLAG_Z = ~z;
                FLAG_C = ~c;
            end
        end
        @(negedge CLOCK);
        if (keep_run) begin
            chk({tag, "_refetch"}, CTRL, C_PC_EN);
            chk({tag, "_refetch_busy"}, BUSY, 1'b1);
        end else begin
            chk({tag, "_end_idle"}, BUSY, 1'b0);
            chk({tag, "_end_ctrl"}, CTRL, 16'h0000);
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        INSTRUCTION = 16'h0000;
        FLAG_Z = 1'b0;
        FLAG_C = 1'b0;
        RUN = 1'b0;
        STEP_MODE = 1'b0;
        STEP = 1'b0;
        for (int i = 0; i < 12; i++) exp_tab[i] = 16'h0000;

        // Reset state
        repeat (2) @(negedge CLOCK);
        chk("rst_ctrl", CTRL, 16'h0000);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_halted", HALTED, 1'b0);
        RESET_N = 1'b1;
        repeat (3) begin
            @(negedge CLOCK);
            chk("idle_norun", BUSY, 1'b0);
        end

        // Reset asserted in F1_LAT clears CTRL without waiting for a clock
        INSTRUCTION = 16'h507B;
        RUN = 1'b1;
        repeat (4) @(negedge CLOCK);
        chk("f1lat_ctrl", CTRL, C_RAM_EN | C_IR_LOAD | C_PC_COUNT);
        #1 RESET_N = 1'b0;
        #1;
        chk("async_rst_ctrl", CTRL, 16'h0000);
        chk("async_rst_busy", BUSY, 1'b0);
        @(negedge CLOCK);
        RUN = 1'b0;
        RESET_N = 1'b1;
        repeat (3) begin
            @(negedge CLOCK);
            chk("post_rst_idle", BUSY, 1'b0);
        end

        // LDI: IR->A, 7 cycles
        set_fetch();
        exp_tab[5] = C_IR_EN;
        exp_tab[6] = C_IR_EN | C_A_LOAD;
        run_seq("ldi", 16'h507B, 1'b0, 1'b0, 7, 1'b0);

        // ADD: IR->MAR, RAM->B, ALU->A, 11 cycles
        exp_tab[5]  = C_IR_EN;
        exp_tab[6]  = C_IR_EN | C_MAR_LOAD;
        exp_tab[7]  = C_RAM_EN;
        exp_tab[8]  = C_RAM_EN | C_B_LOAD;
        exp_tab[9]  = C_ALU_EN;
        exp_tab[10] = C_ALU_EN | C_A_LOAD;
        run_seq("add", 16'h2034, 1'b0, 1'b0, 11, 1'b0);

        // SUB: same transfers with ALU_SUB in every execute cycle
        for (int i = 5; i < 11; i++) exp_tab[i] = exp_tab[i] | C_ALU_SUB;
        run_seq("sub", 16'h3035, 1'b1, 1'b1, 11, 1'b0);

        // STA: IR->MAR, A->RAM, 9 cycles
        set_fetch();
        exp_tab[5] = C_IR_EN;
        exp_tab[6] = C_IR_EN | C_MAR_LOAD;
        exp_tab[7] = C_A_EN;
        exp_tab[8] = C_A_EN | C_RAM_LOAD;
        run_seq("sta", 16'h4020, 1'b0, 1'b0, 9, 1'b0);

        // OUT: A->OUT, 7 cycles
        exp_tab[5] = C_A_EN;
        exp_tab[6] = C_A_EN | C_OUT_LOAD;
        run_seq("out", 16'h9000, 1'b0, 1'b0, 7, 1'b0);

        // JZ taken (Z flips after DECODE and must not matter)
        exp_tab[5] = C_IR_EN;
        exp_tab[6] = C_IR_EN | C_PC_LOAD;
        run_seq("jz_taken", 16'h7010, 1'b1, 1'b0, 7, 1'b0);

        // JZ not taken with RUN held: 5 cycles, next fetch in cycle 6
        set_fetch();
        run_seq("jz_not", 16'h7010, 1'b0, 1'b1, 5, 1'b1);
        RUN = 1'b0;
        repeat (4) @(negedge CLOCK);
        chk("jz_not_2nd_decode", CTRL, 16'h0000);
        @(negedge CLOCK);
        chk("jz_not_2nd_idle", BUSY, 1'b0);

        // Undefined opcode behaves as NOP
        run_seq("undef", 16'hC123, 1'b0, 1'b0, 5, 1'b0);

        // Single-step: one pulse -> one instruction; a pulse while busy is dropped
        STEP_MODE = 1'b1;
        RUN = 1'b1;
        INSTRUCTION = 16'h507B;
        exp_tab[5] = C_IR_EN;
        exp_tab[6] = C_IR_EN | C_A_LOAD;
        repeat (3) begin
            @(negedge CLOCK);
            chk("step_wait", BUSY, 1'b0);
        end
        STEP = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLOCK);
            chk("step_ctrl", CTRL, exp_tab[i]);
            chk("step_busy", BUSY, 1'b1);
            if (i == 1) STEP = 1'b0;
            if (i == 2) STEP = 1'b1;
            if (i == 3) STEP = 1'b0;
        end
        repeat (4) begin
            @(negedge CLOCK);
            chk("step_after_idle", BUSY, 1'b0);
            chk("step_after_ctrl", CTRL, 16'h0000);
        end

        // HLT: fetch, then HALT held regardless of RUN/STEP until reset
        STEP_MODE = 1'b0;
        INSTRUCTION = 16'hF000;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK);
            chk("hlt_fetch", CTRL, exp_tab[i]);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK);
            chk("halt_halted", HALTED, 1'b1);
            chk("halt_ctrl", CTRL, 16'h0000);
            chk("halt_busy", BUSY, 1'b0);
            RUN = i[0];
            STEP = i[1];
            STEP_MODE = i[2];
        end
        RESET_N = 1'b0;
        #1;
        chk("halt_rst_halted", HALTED, 1'b0);
        chk("halt_rst_busy", BUSY, 1'b0);
        @(negedge CLOCK);
        RUN = 1'b0;
        STEP = 1'b0;
        RESET_N = 1'b1;
        @(negedge CLOCK);
        chk("post_halt_idle", HALTED, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
